// File: rtl/gpio_access_arbiter.sv
// GPIO pin-bank owner: round-robin arbitration between requesters with serialised
// masked read-modify-write of the output-data and active-low output-enable registers.
module gpio_access_arbiter #(
    parameter int unsigned GPIO_DATA_WIDTH = 16,
    parameter int unsigned NUM_REQ         = 2
) (
    input  logic                               pclk,
    input  logic                               p_reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [2*NUM_REQ-1:0]               op,
    input  logic [NUM_REQ*GPIO_DATA_WIDTH-1:0] wdata,
    input  logic [NUM_REQ*GPIO_DATA_WIDTH-1:0] wmask,
    output logic [NUM_REQ-1:0]                 ack,
    output logic [GPIO_DATA_WIDTH-1:0]         rdata,
    output logic                               err,
    output logic [2:0]                         gnt_idx,
    input  logic [GPIO_DATA_WIDTH-1:0]         gpio_pin_in,
    output logic [GPIO_DATA_WIDTH-1:0]         gpio_pin_out,
    output logic [GPIO_DATA_WIDTH-1:0]         n_gpio_pin_oe
);

    localparam int unsigned W    = GPIO_DATA_WIDTH;
    localparam int          NReq = int'(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e               state_q;
    logic [2:0]           ptr_q;
    logic [2:0]           gnt_q;
    logic [1:0]           op_q;
    logic [W-1:0]         wdata_q;
    logic [W-1:0]         wmask_q;
    logic [W-1:0]         out_q;
    logic [W-1:0]         noe_q;
    logic [W-1:0]         sync1_q;
    logic [W-1:0]         sync2_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 err_q;
    logic [W-1:0]         rdata_q;

    logic [2:0]           win_idx;
    int                   win_dist;
    logic [1:0]           sel_op;
    logic [W-1:0]         sel_wdata;
    logic [W-1:0]         sel_wmask;

    logic [W-1:0]         out_d;
    logic [W-1:0]         noe_d;
    logic [W-1:0]         rdata_d;
    logic                 err_d;
    logic [2:0]           ptr_d;

    // Winner is the requester at the smallest rotational distance from the pointer.
    always_comb begin
        win_idx  = '0;
        win_dist = NReq;
        for (int i = 0; i < NReq; i++) begin
            if (req[i] && (((i + NReq - int'(ptr_q)) % NReq) < win_dist)) begin
                win_dist = (i + NReq - int'(ptr_q)) % NReq;
                win_idx  = 3'(i);
            end
        end
    end

    always_comb begin
        sel_op    = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int i = 0; i < NReq; i++) begin
            if (win_idx == 3'(i)) begin
                sel_op    = op[2*i +: 2];
                sel_wdata = wdata[i*W +: W];
                sel_wmask = wmask[i*W +: W];
            end
        end
    end

    always_comb begin
        out_d   = out_q;
        noe_d   = noe_q;
        rdata_d = '0;
        err_d   = 1'b0;
        unique case (op_q)
            2'b00: rdata_d = sync2_q;
            2'b01: begin
                out_d   = (out_q & ~wmask_q) | (wdata_q & wmask_q);
                rdata_d = out_d;
            end
            2'b10: begin
                noe_d   = (noe_q & ~wmask_q) | (~wdata_q & wmask_q);
                rdata_d = ~noe_d;
            end
            2'b11: err_d = 1'b1;
        endcase
        ptr_d = (gnt_q == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_q + 3'd1;
    end

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            out_q   <= '0;
            noe_q   <= '1;
            sync1_q <= '0;
            sync2_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            sync1_q <= gpio_pin_in;
            sync2_q <= sync1_q;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        gnt_q   <= win_idx;
                        op_q    <= sel_op;
                        wdata_q <= sel_wdata;
                        wmask_q <= sel_wmask;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    out_q   <= out_d;
                    noe_q   <= noe_d;
                    rdata_q <= rdata_d;
                    err_q   <= err_d;
                    for (int i = 0; i < NReq; i++) begin
                        ack_q[i] <= (gnt_q == 3'(i));
                    end
                    ptr_q   <= ptr_d;
                    state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign gnt_idx       = gnt_q;
    assign gpio_pin_out  = out_q;
    assign n_gpio_pin_oe = noe_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Bench for gpio_access_arbiter: directed scenarios followed by randomized multi-requester
// traffic checked against a behavioural register/round-robin model.
module tb_gpio_access_arbiter;

    localparam int W  = 16;
    localparam int NR = 2;

    logic              pclk = 1'b0;
    logic              p_reset;
    logic [NR-1:0]     req;
    logic [2*NR-1:0]   op;
    logic [NR*W-1:0]   wdata;
    logic [NR*W-1:0]   wmask;
    logic [NR-1:0]     ack;
    logic [W-1:0]      rdata;
    logic              err;
    logic [2:0]        gnt_idx;
    logic [W-1:0]      gpio_pin_in;
    logic [W-1:0]      gpio_pin_out;
    logic [W-1:0]      n_gpio_pin_oe;

    gpio_access_arbiter #(
        .GPIO_DATA_WIDTH(W),
        .NUM_REQ        (NR)
    ) dut (
        .pclk         (pclk),
        .p_reset      (p_reset),
        .req          (req),
        .op           (op),
        .wdata        (wdata),
        .wmask        (wmask),
        .ack          (ack),
        .rdata        (rdata),
        .err          (err),
        .gnt_idx      (gnt_idx),
        .gpio_pin_in  (gpio_pin_in),
        .gpio_pin_out (gpio_pin_out),
        .n_gpio_pin_oe(n_gpio_pin_oe)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    // Reference state: pin registers, synchronised pin value, round-robin pointer.
    logic [W-1:0] m_out;
    logic [W-1:0] m_noe;
    logic [W-1:0] m_pin;
    int           m_ptr;
    logic [W-1:0] exp_rd;
    logic         exp_err;

    logic [NR-1:0] pend;
    logic [1:0]    p_op [NR];
    logic [W-1:0]  p_d  [NR];
    logic [W-1:0]  p_m  [NR];
    int            win;
    int            n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] d,
                           input logic [W-1:0] m);
        req[i]          = 1'b1;
        op[2*i +: 2]    = o;
        wdata[i*W +: W] = d;
        wmask[i*W +: W] = m;
    endtask

    task automatic model_exec(input int who, input logic [1:0] o, input logic [W-1:0] d,
                              input logic [W-1:0] m);
        exp_err = 1'b0;
        case (o)
            2'b00: exp_rd = m_pin;
            2'b01: begin
                m_out  = (m_out & ~m) | (d & m);
                exp_rd = m_out;
            end
            2'b10: begin
                m_noe  = (m_noe & ~m) | (~d & m);
                exp_rd = ~m_noe;
            end
            default: begin
                exp_rd  = '0;
                exp_err = 1'b1;
            end
        endcase
        m_ptr = (who + 1) % NR;
    endtask

    task automatic check_done(input string tag, input int who);
        chk({tag, "_ack"}, 32'(ack), 32'(1) << who);
        chk({tag, "_gnt"}, 32'(gnt_idx), 32'(who));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        chk({tag, "_out"}, 32'(gpio_pin_out), 32'(m_out));
        chk({tag, "_noe"}, 32'(n_gpio_pin_oe), 32'(m_noe));
    endtask

    task automatic wait_ack(output int cnt);
        cnt = 0;
        do begin
            @(negedge pclk);
            cnt++;
        end while (ack == '0 && cnt < 20);
        chk("ack_seen", 32'(ack != '0), 32'd1);
    endtask

    initial begin
        p_reset     = 1'b1;
        req         = '0;
        op          = '0;
        wdata       = '0;
        wmask       = '0;
        gpio_pin_in = '0;
        m_out       = '0;
        m_noe       = '1;
        m_pin       = '0;
        m_ptr       = 0;
        pend        = '0;
        repeat (2) @(negedge pclk);
        chk("rst_noe", 32'(n_gpio_pin_oe), 32'hFFFF);
        chk("rst_out", 32'(gpio_pin_out), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_gnt", 32'(gnt_idx), 32'h0);
        p_reset = 1'b0;

        // Masked write of output data then output enable.
        @(negedge pclk);
        set_req(0, 2'b01, 16'hA5A5, 16'h00FF);
        @(negedge pclk);
        chk("wr_out_early", 32'(ack), 32'h0);
        @(negedge pclk);
        model_exec(0, 2'b01, 16'hA5A5, 16'h00FF);
        check_done("wr_out", 0);
        chk("wr_out_lit", 32'(gpio_pin_out), 32'h00A5);
        req = '0;
        @(negedge pclk);
        chk("ack_one_cycle", 32'(ack), 32'h0);
        chk("rdata_one_cycle", 32'(rdata), 32'h0);
        set_req(0, 2'b10, 16'hFFFF, 16'h000F);
        @(negedge pclk);
        chk("wr_oe_early", 32'(ack), 32'h0);
        @(negedge pclk);
        model_exec(0, 2'b10, 16'hFFFF, 16'h000F);
        check_done("wr_oe", 0);
        chk("wr_oe_lit", 32'(n_gpio_pin_oe), 32'hFFF0);
        chk("wr_oe_rd_lit", 32'(rdata), 32'h000F);
        req = '0;

        // Pin read through the synchroniser, pin settled beforehand.
        gpio_pin_in = 16'h1234;
        m_pin       = 16'h1234;
        repeat (3) @(negedge pclk);
        set_req(1, 2'b00, 16'h0, 16'h0);
        @(negedge pclk);
        chk("rd_early", 32'(ack), 32'h0);
        @(negedge pclk);
        model_exec(1, 2'b00, 16'h0, 16'h0);
        check_done("rd", 1);
        chk("rd_lit", 32'(rdata), 32'h1234);
        req = '0;

        // Contention: both held, pointer at 0 -> 0,1,0,1 with 3-cycle spacing.
        @(negedge pclk);
        chk("ptr_before_cont", 32'(m_ptr), 32'd0);
        set_req(0, 2'b01, 16'h1111, 16'hFFFF);
        set_req(1, 2'b01, 16'h2222, 16'hFF00);
        for (int g = 0; g < 4; g++) begin
            wait_ack(n);
            chk("cont_spacing", 32'(n), (g == 0) ? 32'd2 : 32'd3);
            if (g % 2 == 0) model_exec(0, 2'b01, 16'h1111, 16'hFFFF);
            else            model_exec(1, 2'b01, 16'h2222, 16'hFF00);
            check_done("cont", g % 2);
        end
        req = '0;

        // Reserved opcode.
        @(negedge pclk);
        set_req(0, 2'b11, 16'hFFFF, 16'hFFFF);
        repeat (2) @(negedge pclk);
        model_exec(0, 2'b11, 16'hFFFF, 16'hFFFF);
        check_done("rsvd", 0);
        req = '0;
        @(negedge pclk);
        chk("rsvd_err_clear", 32'(err), 32'h0);

        // Reset in the cycle after grant aborts the write.
        set_req(0, 2'b01, 16'hFFFF, 16'hFFFF);
        @(negedge pclk);
        p_reset = 1'b1;
        @(negedge pclk);
        chk("abort_ack0", 32'(ack), 32'h0);
        @(negedge pclk);
        chk("abort_ack1", 32'(ack), 32'h0);
        req     = '0;
        p_reset = 1'b0;
        m_out   = '0;
        m_noe   = '1;
        m_ptr   = 0;
        chk("abort_out", 32'(gpio_pin_out), 32'h0);
        chk("abort_noe", 32'(n_gpio_pin_oe), 32'hFFFF);
        repeat (2) @(negedge pclk);
        chk("abort_noack", 32'(ack), 32'h0);
        set_req(1, 2'b01, 16'hBEEF, 16'hFFFF);
        repeat (2) @(negedge pclk);
        model_exec(1, 2'b01, 16'hBEEF, 16'hFFFF);
        check_done("post_abort", 1);
        req = '0;

        // Randomized traffic; losers stay pending with their operands unchanged.
        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && ($urandom % 2 == 1)) begin
                    pend[i] = 1'b1;
                    p_op[i] = 2'($urandom % 4);
                    p_d[i]  = W'($urandom);
                    p_m[i]  = ($urandom % 8 == 0) ? '0 : W'($urandom);
                    set_req(i, p_op[i], p_d[i], p_m[i]);
                end
            end
            if (pend == '0) begin
                pend[0] = 1'b1;
                p_op[0] = 2'b01;
                p_d[0]  = W'($urandom);
                p_m[0]  = W'($urandom);
                set_req(0, p_op[0], p_d[0], p_m[0]);
            end
            win = -1;
            for (int j = 0; j < NR; j++) begin
                if (win < 0 && pend[(m_ptr + j) % NR]) win = (m_ptr + j) % NR;
            end
            wait_ack(n);
            model_exec(win, p_op[win], p_d[win], p_m[win]);
            check_done("rand", win);
            pend[win]   = 1'b0;
            req[win]    = 1'b0;
            gpio_pin_in = W'($urandom);
            m_pin       = gpio_pin_in;
        end
        req = '0;
        repeat (3) @(negedge pclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
